// File: rtl/pwm_pkg.sv
// Shared types for the multi-channel PWM bank: operating modes and FSM states.
package pwm_pkg;

    // Operating mode as presented on the mode input; encoding 3 falls back to OFF.
    typedef enum logic [1:0] {
        OFF   = 2'd0,
        CONT  = 2'd1,
        BURST = 2'd2
    } mode_t;

    // Top-level controller states.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/pwm_channel_bank_compare.sv
// One PWM channel: shadowed duty (and phase when PWM_PHASE_EN is defined),
// effective-count arithmetic and the registered output bit.
module pwm_compare
    import pwm_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         active,
    input  logic [N-1:0] cnt,
    input  logic [N-1:0] duty,
`ifdef PWM_PHASE_EN
    input  logic [N-1:0] period_s,
    input  logic [N-1:0] phase,
`endif
    output logic         out
);

    logic [N-1:0] duty_s_reg;
    logic [N-1:0] eff_cnt;
    logic         out_reg;
    logic         out_next;

`ifdef PWM_PHASE_EN
    logic [N-1:0] phase_s_reg;
    logic [N-1:0] ph;

    // Rotate the shared count by this channel's phase; out-of-range phase acts as zero.
    // cnt < ph < period_s here, so the wrapped sum stays inside 0..period_s-1.
    always_comb begin
        ph      = (phase_s_reg >= period_s) ? '0 : phase_s_reg;
        eff_cnt = (cnt >= ph) ? (cnt - ph) : (cnt + period_s - ph);
    end

    // Phase shadow is refreshed together with duty so a period always uses one consistent set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_s_reg <= '0;
        end else if (load) begin
            phase_s_reg <= phase;
        end
    end
`else
    assign eff_cnt = cnt;
`endif

    // Output is high while the effective count is below the shadowed duty.
    assign out_next = active && (eff_cnt < duty_s_reg);

    // Shadow duty and registered output; inactive cycles force the output low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_s_reg <= '0;
            out_reg    <= 1'b0;
        end else begin
            if (load) begin
                duty_s_reg <= duty;
            end
            out_reg <= out_next;
        end
    end

    assign out = out_reg;

endmodule

// File: rtl/pwm_channel_bank.sv
// Multi-channel PWM bank: one shared period counter, M compare channels,
// continuous or counted-burst operation. Defining PWM_PHASE_EN adds the
// per-channel phase input and phase-shifted compare.
module pwm_channel_bank
    import pwm_pkg::*;
#(
    parameter int N  = 8,
    parameter int M  = 4,
    parameter int BW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ena,
    input  logic [1:0]     mode,
    input  logic           start,
    input  logic [N-1:0]   period,
    input  logic [M*N-1:0] duty,
    input  logic [BW-1:0]  burst_count,
`ifdef PWM_PHASE_EN
    input  logic [M*N-1:0] phase,
`endif
    output logic [M-1:0]   out,
    output logic           tick,
    output logic           busy,
    output logic           done
);

    state_t        state_reg,    state_next;
    mode_t         mode_l_reg,   mode_l_next;
    logic [N-1:0]  cnt_reg,      cnt_next;
    logic [N-1:0]  period_s_reg, period_s_next;
    logic [BW-1:0] burst_reg,    burst_next;
    logic          tick_reg,     tick_next;
    logic          done_reg,     done_next;
    logic          load_shadow;
    logic          active;
    logic          wrap;

    // Last count of the period; periods of 0 or 1 wrap every cycle with the counter parked at 0.
    assign wrap = (period_s_reg <= N'(1)) || (cnt_reg == period_s_reg - N'(1));

    // Next-state logic: entry, abort on mode change, burst completion, then wrap/advance.
    always_comb begin
        state_next    = state_reg;
        mode_l_next   = mode_l_reg;
        cnt_next      = cnt_reg;
        period_s_next = period_s_reg;
        burst_next    = burst_reg;
        tick_next     = 1'b0;
        done_next     = 1'b0;
        load_shadow   = 1'b0;
        active        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ena) begin
                    if (mode == CONT) begin
                        state_next    = RUN;
                        mode_l_next   = CONT;
                        cnt_next      = '0;
                        period_s_next = period;
                        load_shadow   = 1'b1;
                    end else if ((mode == BURST) && start) begin
                        if (burst_count == '0) begin
                            // Empty burst: acknowledge immediately without ever running.
                            done_next = 1'b1;
                        end else begin
                            state_next    = RUN;
                            mode_l_next   = BURST;
                            burst_next    = burst_count;
                            cnt_next      = '0;
                            period_s_next = period;
                            load_shadow   = 1'b1;
                        end
                    end
                end
            end
            RUN: begin
                if (ena) begin
                    if (mode != mode_l_reg) begin
                        // Abort: outputs drop next cycle and no done is reported.
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        active    = 1'b1;
                        tick_next = (cnt_reg == '0);
                        if (wrap) begin
                            cnt_next      = '0;
                            period_s_next = period;
                            load_shadow   = 1'b1;
                            if (mode_l_reg == BURST) begin
                                if (burst_reg == BW'(1)) begin
                                    state_next = IDLE;
                                    done_next  = 1'b1;
                                    burst_next = '0;
                                end else begin
                                    burst_next = burst_reg - BW'(1);
                                end
                            end
                        end else begin
                            cnt_next = cnt_reg + N'(1);
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Controller state, counters, shadow period and strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            mode_l_reg   <= OFF;
            cnt_reg      <= '0;
            period_s_reg <= '0;
            burst_reg    <= '0;
            tick_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            mode_l_reg   <= mode_l_next;
            cnt_reg      <= cnt_next;
            period_s_reg <= period_s_next;
            burst_reg    <= burst_next;
            tick_reg     <= tick_next;
            done_reg     <= done_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_ch
            pwm_compare #(
                .N(N)
            ) u_cmp (
                .clk      (clk),
                .rst      (rst),
                .load     (load_shadow),
                .active   (active),
                .cnt      (cnt_reg),
                .duty     (duty[gi*N +: N]),
`ifdef PWM_PHASE_EN
                .period_s (period_s_reg),
                .phase    (phase[gi*N +: N]),
`endif
                .out      (out[gi])
            );
        end
    endgenerate

    assign tick = tick_reg;
    assign done = done_reg;
    assign busy = (state_reg == RUN);

endmodule

// File: tb/tb_pwm_channel_bank.sv
// Scoreboard bench for pwm_channel_bank: stimulus pushes hand-derived expected
// outputs per clock; a negedge monitor pops and compares.
module tb_pwm_channel_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [1:0]  mode;
    logic        start;
    logic [7:0]  period;
    logic [31:0] duty;
    logic [3:0]  burst_count;
`ifdef PWM_PHASE_EN
    logic [31:0] phase;
`endif
    logic [3:0]  out;
    logic        tick;
    logic        busy;
    logic        done;

    typedef struct {
        logic [3:0] o;
        logic       t;
        logic       b;
        logic       d;
        string      nm;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_cur;
    int   checks = 0;
    int   errors = 0;

    // ena pattern and expected out[0]/tick for the enable-stretch sequence
    int e_ena[10]  = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    int e_out[10]  = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 1};
    int e_tick[10] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1};

    pwm_channel_bank #(.N(8), .M(4), .BW(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .mode        (mode),
        .start       (start),
        .period      (period),
        .duty        (duty),
        .burst_count (burst_count),
`ifdef PWM_PHASE_EN
        .phase       (phase),
`endif
        .out         (out),
        .tick        (tick),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Queue the expected outputs for the coming edge, then let that edge happen.
    task automatic cyc(input logic [3:0] o, input logic t, input logic b, input logic d, input string nm);
        exp_t e;
        e.o = o; e.t = t; e.b = b; e.d = d; e.nm = nm;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Same, but raise rst right after the edge: outputs must already be zero at the monitor.
    task automatic cyc_arst(input string nm);
        exp_t e;
        e.o = 4'b0; e.t = 1'b0; e.b = 1'b0; e.d = 1'b0; e.nm = nm;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Monitor: compare DUT outputs with the queued expectation once per cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e_cur = exp_q.pop_front();
            checks++;
            if (out !== e_cur.o) begin
                errors++;
                $display("FAIL %s out got %b want %b at %0t", e_cur.nm, out, e_cur.o, $time);
            end
            checks++;
            if (tick !== e_cur.t) begin
                errors++;
                $display("FAIL %s tick got %b want %b at %0t", e_cur.nm, tick, e_cur.t, $time);
            end
            checks++;
            if (busy !== e_cur.b) begin
                errors++;
                $display("FAIL %s busy got %b want %b at %0t", e_cur.nm, busy, e_cur.b, $time);
            end
            checks++;
            if (done !== e_cur.d) begin
                errors++;
                $display("FAIL %s done got %b want %b at %0t", e_cur.nm, done, e_cur.d, $time);
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1; ena = 1'b0; mode = 2'd0; start = 1'b0;
        period = 8'd0; duty = 32'd0; burst_count = 4'd0;
`ifdef PWM_PHASE_EN
        phase = 32'd0;
`endif
        cyc(4'b0000, 0, 0, 0, "reset");
        cyc(4'b0000, 0, 0, 0, "reset");
        rst = 1'b0;

        // Continuous, P=5, duty ch0..3 = 0,2,5,7
        ena = 1'b1; mode = 2'd1; period = 8'd5; duty = {8'd7, 8'd5, 8'd2, 8'd0};
        cyc(4'b0000, 0, 1, 0, "cont_entry");
        for (int j = 1; j <= 15; j++) begin
            int k;
            k = (j - 1) % 5;
            cyc({1'b1, 1'b1, (k < 2), 1'b0}, (k == 0), 1'b1, 1'b0, "cont");
        end
        cyc_arst("async_rst");
        cyc(4'b0000, 0, 0, 0, "rst_hold");
        cyc(4'b0000, 0, 0, 0, "rst_hold");
        rst = 1'b0; mode = 2'd0;
        cyc(4'b0000, 0, 0, 0, "idle_off");

        // Burst: P=4, duty ch0=1, 3 periods; a second start mid-burst is ignored
        mode = 2'd2; period = 8'd4; duty = 32'h0000_0001; burst_count = 4'd3; start = 1'b1;
        cyc(4'b0000, 0, 1, 0, "burst_entry");
        for (int j = 1; j <= 14; j++) begin
            int k;
            k = (j - 1) % 4;
            start = (j == 6);
            if (j <= 12)
                cyc({3'b000, (k == 0)}, (k == 0), (j < 12), (j == 12), "burst");
            else
                cyc(4'b0000, 0, 0, 0, "burst_after");
        end

        // start while disabled is ignored
        ena = 1'b0; start = 1'b1;
        cyc(4'b0000, 0, 0, 0, "start_no_ena");
        start = 1'b0;
        cyc(4'b0000, 0, 0, 0, "start_no_ena");

        // Zero-length burst: done next cycle, never busy, no tick
        ena = 1'b1; burst_count = 4'd0; start = 1'b1;
        cyc(4'b0000, 0, 0, 1, "burst0");
        start = 1'b0;
        cyc(4'b0000, 0, 0, 0, "burst0_after");
        cyc(4'b0000, 0, 0, 0, "burst0_after");

        // Shadowing: P=6, duty ch0 1 -> 3 while counter=2; new width only from next period
        mode = 2'd1; period = 8'd6; duty = 32'h0000_0001;
        cyc(4'b0000, 0, 1, 0, "shadow_entry");
        for (int j = 1; j <= 18; j++) begin
            int k;
            int dv;
            k  = (j - 1) % 6;
            dv = (j <= 6) ? 1 : 3;
            if (j == 3) duty = 32'h0000_0003;
            cyc({3'b000, (k < dv)}, (k == 0), 1'b1, 1'b0, "shadow");
        end

        // ena low for 3 cycles with counter=2: period stretched to 9
        for (int m = 0; m < 10; m++) begin
            ena = e_ena[m][0];
            cyc({3'b000, e_out[m][0]}, e_tick[m][0], 1'b1, 1'b0, "ena_stretch");
        end

        // CONT -> OFF: idle and outputs low next cycle, no done
        mode = 2'd0;
        cyc(4'b0000, 0, 0, 0, "abort");
        cyc(4'b0000, 0, 0, 0, "abort_after");

        // P=1: counter parked at 0, tick every enabled cycle
        mode = 2'd1; period = 8'd1; duty = 32'h0000_0001;
        cyc(4'b0000, 0, 1, 0, "p1_entry");
        for (int j = 0; j < 4; j++) begin
            cyc(4'b0001, 1, 1, 0, "p1");
        end
        mode = 2'd0;
        cyc(4'b0000, 0, 0, 0, "p1_abort");

`ifdef PWM_PHASE_EN
        // Phase: P=8, duty 2, phase ch0=0, ch1=3, ch2=9 (acts as 0), ch3 duty 0
        mode = 2'd1; period = 8'd8; duty = 32'h0002_0202; phase = {8'd0, 8'd9, 8'd3, 8'd0};
        cyc(4'b0000, 0, 1, 0, "phase_entry");
        for (int j = 1; j <= 16; j++) begin
            int k;
            k = (j - 1) % 8;
            cyc({1'b0, (k < 2), (k == 3 || k == 4), (k < 2)}, (k == 0), 1'b1, 1'b0, "phase");
        end
        mode = 2'd0;
        cyc(4'b0000, 0, 0, 0, "phase_abort");
`endif

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
